hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Parametrised stall/forward controller for the pipelined MIPS core. Tracks every in-flight
//  GRF producer from E to W, counting down its Tnew. Compares D-stage sources against that
//  record. Drives the D stall, the D forward-select muxes and the E-stage bubble. Consumes the
//  decoder's GRFwen/GRFwdst/TNinit, plus per-source Tuse and the MUDV busy flag.
// PARAMETERS
//  STAGES  3   tracked producer stages after D (1=E ... STAGES=W)
//  TN_W    2   Tnew/Tuse field width
//  REG_W   5   GRF address width
//  FS_W    2   forward-select width, must satisfy 2**FS_W >= STAGES+1
// PORTS
//  clk          in   1      clock; single clock domain
//  reset        in   1      synchronous, active-high
//  flush        in   1      pipeline flush (exception/ERET): invalidate all tracked entries
//  d_valid      in   1      D holds a real instruction
//  d_rs, d_rt   in   REG_W  D source register addresses
//  d_rs_tuse    in   TN_W   cycles until D needs rs (max value = not used)
//  d_rt_tuse    in   TN_W   as d_rs_tuse, for rt
//  d_wen        in   1      D instruction writes GRF
//  d_wdst       in   REG_W  D destination register
//  d_tnew       in   TN_W   Tnew of D instruction on entering E
//  d_mudv       in   1      D instruction uses MUDV (trigger, MT or MF)
//  mudv_busy    in   1      MUDV operation in progress
//  stall        out  1      freeze PC/F/D; insert bubble into E
//  fwd_rs_sel   out  FS_W   0 = GRF, k = forward from stage k
//  fwd_rt_sel   out  FS_W   as fwd_rs_sel, for rt
//  stall_cnt    out  32     (HAZARD_PERF_EN only) stalled-cycle count
// BEHAVIOUR
//  Entry record e[k], k=1..STAGES, holds {v, dst, tnew}. Only entries with v=1 take part.
//  Record update on posedge clk:
//   - reset or flush: every v <= 0.
//   - otherwise, e[1] <= (d_valid & d_wen & ~stall & d_wdst!=0) ? {1, d_wdst, d_tnew} : bubble.
//   - otherwise, e[k+1] <= {e[k].v, e[k].dst, sat_dec(e[k].tnew)}; sat_dec(0)=0.
//   - the oldest entry drops out after stage STAGES.
//  Matching for source s (rs or rt):
//   - match(k,s) = e[k].v & e[k].dst==s & s!=0.
//   - youngest match = the match with the smallest k; only the youngest match counts.
//  Combinational outputs, zero cycles of latency:
//   - stall = d_valid & (youngest match tnew > Tuse, for rs or rt, | d_mudv & mudv_busy).
//   - fwd_s_sel = k of the youngest match if its tnew==0, else 0.
//   - When tnew>0 and tnew<=Tuse there is no stall and fwd=0; a later stage forwards the value.
//  Reset state: all v=0, so stall=0 and fwd_*_sel=0. stall_cnt=0.
//  Edge cases:
//   - d_valid=0: stall=0; forward selects are still computed, and are don't-care.
//   - flush and stall together: flush wins and the record clears. stall may be 1 during the
//     flush cycle; that has no effect.
//   - rs==rt: both selects are computed identically.
//   - a reset in the middle of a stall sequence ends it on the next cycle.
//  Tnew counts saturate at 0. Tuse is never decremented (D is frozen).
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - adds port stall_cnt.
//   - stall_cnt increments each cycle stall=1 & ~flush, saturates at 32'hFFFF_FFFF.
//   - stall_cnt clears on reset only.
//  HAZARD_PERF_EN undefined: no port, no counter logic.
// STRUCTURE
//  Shared header haz.vh:
//   - entry field widths.
//   - FWD_GRF=0.
//   - TUSE_NONE = {TN_W{1'b1}}.
//   - sat_dec function.
//  Sub-module haz_entry (one stage register with saturating tnew decrement), instantiated
//  STAGES times via generate.
//  Match/priority logic is a generate loop scanned from the oldest stage to the youngest, so
//  the youngest match wins.
// TESTING
//  Defaults: STAGES=3.
//  1. lw $8, then D: rs=8, tuse=0 -> stall=1 for 2 cycles, then stall=0 with fwd_rs_sel=3.
//  2. add $9 (tnew 1) in E, D beq with rt=9, tuse=0 -> stall 1 cycle, then fwd_rt_sel=2,
//     fwd_rs_sel=0.
//  3. Producer dst=0 in any stage, consumer rs=0 -> stall=0, fwd_rs_sel=0.
//  4. Same register in two stages: e1 dst=5 tnew=1, e2 dst=5 tnew=0; D rs=5, tuse=1
//     -> stall=0, fwd_rs_sel=0 (youngest wins, not e2).
//  5. lw in E plus a dependent D, assert flush -> next cycle stall=0, all selects 0.
//     Reset mid-stall -> same result.
//  6. d_mudv=1 & mudv_busy=1 -> stall=1; drop d_valid -> stall=0.
//     Under HAZARD_PERF_EN, 7 stalled cycles -> stall_cnt=7.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared constants and helpers for the stall/forward controller.
package hazard_unit_pkg;

  // Forward-select value meaning "read the GRF, no bypass".
  localparam int unsigned FWD_GRF = 0;

  // Saturating decrement: a producer that is already ready stays ready.
  function automatic int unsigned sat_dec(input int unsigned x);
    return (x == 0) ? 0 : x - 1;
  endfunction

endpackage

// File: rtl/hazard_unit_entry.sv
// One tracked producer stage: {v, dst, tnew}. Stages past the first age tnew by one
// on the way in; a flush or reset empties the slot.
module hazard_unit_entry
  import hazard_unit_pkg::*;
#(
  parameter int unsigned TN_W  = 2,
  parameter int unsigned REG_W = 5,
  parameter bit          DEC   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_v,
  input  logic [REG_W-1:0] in_dst,
  input  logic [TN_W-1:0]  in_tnew,
  output logic             v,
  output logic [REG_W-1:0] dst,
  output logic [TN_W-1:0]  tnew
);

  // Stage register; tnew counts down toward 0 as the producer advances.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v    <= 1'b0;
      dst  <= '0;
      tnew <= '0;
    end else begin
      v    <= in_v;
      dst  <= in_dst;
      tnew <= DEC ? TN_W'(sat_dec(32'(in_tnew))) : in_tnew;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/forward controller for the pipelined MIPS core.
// Optional: define HAZARD_PERF_EN to add the stall_cnt performance counter port.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TN_W   = 2,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned FS_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [TN_W-1:0]  d_rs_tuse,
  input  logic [TN_W-1:0]  d_rt_tuse,
  input  logic             d_wen,
  input  logic [REG_W-1:0] d_wdst,
  input  logic [TN_W-1:0]  d_tnew,
  input  logic             d_mudv,
  input  logic             mudv_busy,
  output logic             stall,
  output logic [FS_W-1:0]  fwd_rs_sel,
  output logic [FS_W-1:0]  fwd_rt_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  logic             e_v   [1:STAGES];
  logic [REG_W-1:0] e_dst [1:STAGES];
  logic [TN_W-1:0]  e_tn  [1:STAGES];

  // Priority chains: index k holds the youngest match among stages k+1..STAGES.
  logic             rs_hit [0:STAGES];
  logic [TN_W-1:0]  rs_tn  [0:STAGES];
  logic [FS_W-1:0]  rs_k   [0:STAGES];
  logic             rt_hit [0:STAGES];
  logic [TN_W-1:0]  rt_tn  [0:STAGES];
  logic [FS_W-1:0]  rt_k   [0:STAGES];

  logic e1_ins;
  logic rs_stall;
  logic rt_stall;

  // A real GRF writer leaving D unstalled enters E; anything else is a bubble.
  assign e1_ins = d_valid & d_wen & ~stall & (d_wdst != '0);

  // Producer record, one register per stage from E to W.
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic             s_v;
    logic [REG_W-1:0] s_dst;
    logic [TN_W-1:0]  s_tn;

    if (k == 1) begin : g_head
      assign s_v   = e1_ins;
      assign s_dst = d_wdst;
      assign s_tn  = d_tnew;
    end else begin : g_tail
      assign s_v   = e_v[k-1];
      assign s_dst = e_dst[k-1];
      assign s_tn  = e_tn[k-1];
    end

    hazard_unit_entry #(
      .TN_W  (TN_W),
      .REG_W (REG_W),
      .DEC   (k != 1)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .in_v    (s_v),
      .in_dst  (s_dst),
      .in_tnew (s_tn),
      .v       (e_v[k]),
      .dst     (e_dst[k]),
      .tnew    (e_tn[k])
    );
  end

  assign rs_hit[STAGES] = 1'b0;
  assign rs_tn[STAGES]  = '0;
  assign rs_k[STAGES]   = FS_W'(FWD_GRF);
  assign rt_hit[STAGES] = 1'b0;
  assign rt_tn[STAGES]  = '0;
  assign rt_k[STAGES]   = FS_W'(FWD_GRF);

  // Scan oldest to youngest so a younger match overrides an older one; $0 never matches.
  for (genvar k = STAGES; k >= 1; k--) begin : g_match
    logic m_rs;
    logic m_rt;

    assign m_rs = e_v[k] & (e_dst[k] == d_rs) & (d_rs != '0);
    assign m_rt = e_v[k] & (e_dst[k] == d_rt) & (d_rt != '0);

    assign rs_hit[k-1] = m_rs | rs_hit[k];
    assign rs_tn[k-1]  = m_rs ? e_tn[k] : rs_tn[k];
    assign rs_k[k-1]   = m_rs ? FS_W'(k) : rs_k[k];
    assign rt_hit[k-1] = m_rt | rt_hit[k];
    assign rt_tn[k-1]  = m_rt ? e_tn[k] : rt_tn[k];
    assign rt_k[k-1]   = m_rt ? FS_W'(k) : rt_k[k];
  end

  // Stall while the youngest producer is not ready by the time D needs it, or MUDV is busy.
  assign rs_stall = rs_hit[0] & (rs_tn[0] > d_rs_tuse);
  assign rt_stall = rt_hit[0] & (rt_tn[0] > d_rt_tuse);
  assign stall    = d_valid & (rs_stall | rt_stall | (d_mudv & mudv_busy));

  // Bypass only from a producer whose result already exists; otherwise a later stage will.
  assign fwd_rs_sel = (rs_hit[0] && (rs_tn[0] == '0)) ? rs_k[0] : FS_W'(FWD_GRF);
  assign fwd_rt_sel = (rt_hit[0] && (rt_tn[0] == '0)) ? rt_k[0] : FS_W'(FWD_GRF);

`ifdef HAZARD_PERF_EN
  // Saturating count of cycles that actually held D (flush cycles excluded).
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic against a producer-list model.
module tb_hazard_unit;

  localparam int STAGES = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic       d_wen;
  logic [4:0] d_wdst;
  logic [1:0] d_tnew;
  logic       d_mudv;
  logic       mudv_busy;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: list of in-flight producers, each with the Tnew it had entering E and its age
  // (age 1 = E stage). Current readiness is derived arithmetically from the age.
  typedef struct {
    int dst;
    int tnew0;
    int age;
  } prod_t;

  prod_t q[$];
  longint m_cnt = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rs_tuse  (d_rs_tuse),
    .d_rt_tuse  (d_rt_tuse),
    .d_wen      (d_wen),
    .d_wdst     (d_wdst),
    .d_tnew     (d_tnew),
    .d_mudv     (d_mudv),
    .mudv_busy  (mudv_busy),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  function automatic void model_src(input int s, input int tuse, output bit st, output int sel);
    int best = -1;
    int cur;
    st  = 1'b0;
    sel = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (s != 0 && q[i].dst == s && (best < 0 || q[i].age < q[best].age)) best = i;
    end
    if (best >= 0) begin
      cur = q[best].tnew0 - (q[best].age - 1);
      if (cur < 0) cur = 0;
      st  = (cur > tuse);
      sel = (cur == 0) ? q[best].age : 0;
    end
  endfunction

  task automatic set_d(input bit v, input int rs, input int rs_tu, input int rt, input int rt_tu,
                       input bit wen, input int wd, input int tn);
    d_valid   = v;
    d_rs      = 5'(rs);
    d_rs_tuse = 2'(rs_tu);
    d_rt      = 5'(rt);
    d_rt_tuse = 2'(rt_tu);
    d_wen     = wen;
    d_wdst    = 5'(wd);
    d_tnew    = 2'(tn);
  endtask

  // Check current outputs against the model, then clock once and advance the model.
  task automatic tick();
    bit st_rs, st_rt, e_stall;
    int sel_rs, sel_rt;
    prod_t nq[$];
    #2;
    model_src(int'(d_rs), int'(d_rs_tuse), st_rs, sel_rs);
    model_src(int'(d_rt), int'(d_rt_tuse), st_rt, sel_rt);
    e_stall = d_valid && (st_rs || st_rt || (d_mudv && mudv_busy));
    n_cmp++;
    assert (stall === e_stall) else begin
      n_err++;
      $error("FAIL stall: got %b expected %b at %0t", stall, e_stall, $time);
    end
    if (d_valid) begin
      n_cmp++;
      assert (fwd_rs_sel === 2'(sel_rs)) else begin
        n_err++;
        $error("FAIL fwd_rs_sel: got %0d expected %0d at %0t", fwd_rs_sel, sel_rs, $time);
      end
      n_cmp++;
      assert (fwd_rt_sel === 2'(sel_rt)) else begin
        n_err++;
        $error("FAIL fwd_rt_sel: got %0d expected %0d at %0t", fwd_rt_sel, sel_rt, $time);
      end
    end
`ifdef HAZARD_PERF_EN
    n_cmp++;
    assert (stall_cnt === 32'(m_cnt)) else begin
      n_err++;
      $error("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, m_cnt, $time);
    end
`endif
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (e_stall && !flush && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        foreach (q[i]) if (q[i].age < STAGES) nq.push_back('{q[i].dst, q[i].tnew0, q[i].age + 1});
        if (d_valid && d_wen && !e_stall && d_wdst != 0)
          nq.push_back('{int'(d_wdst), int'(d_tnew), 1});
        q = nq;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    d_mudv = 1'b0;
    mudv_busy = 1'b0;
    set_d(0, 0, 3, 0, 3, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state: dependent-looking D sees an empty record.
    set_d(1, 8, 0, 9, 0, 0, 0, 0);
    tick();

    // lw $8 then a consumer of $8 at Tuse 0: two stalls, then forward from W.
    set_d(1, 1, 3, 2, 3, 1, 8, 2);
    tick();
    set_d(1, 8, 0, 0, 3, 0, 0, 0);
    repeat (3) tick();
    n_cmp++;
    assert (fwd_rs_sel === 2'd0) else begin
      n_err++;
      $error("FAIL lw_drained: got %0d expected 0", fwd_rs_sel);
    end

    // add $9 (Tnew 1), then beq rt=9: one stall, then forward from M.
    set_d(1, 0, 3, 0, 3, 1, 9, 1);
    tick();
    set_d(1, 3, 0, 9, 0, 0, 0, 0);
    repeat (3) tick();

    // $0 producer never tracked; $0 consumer never matches.
    set_d(1, 0, 3, 0, 3, 1, 0, 2);
    tick();
    set_d(1, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Two producers of $5: the younger (not yet ready) decides.
    set_d(1, 0, 3, 0, 3, 1, 5, 1);
    repeat (2) tick();
    set_d(1, 5, 1, 5, 1, 0, 0, 0);
    tick();

    // Flush during a stall clears the record.
    set_d(1, 0, 3, 0, 3, 1, 8, 2);
    tick();
    set_d(1, 8, 0, 8, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a stall ends it.
    set_d(1, 0, 3, 0, 3, 1, 8, 2);
    tick();
    set_d(1, 8, 0, 0, 3, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // MUDV busy stalls a MUDV user for 7 cycles; invalid D never stalls.
    reset = 1'b1;
    set_d(0, 0, 3, 0, 3, 0, 0, 0);
    tick();
    reset = 1'b0;
    set_d(1, 0, 3, 0, 3, 0, 0, 0);
    d_mudv = 1'b1;
    mudv_busy = 1'b1;
    repeat (7) tick();
    set_d(0, 0, 3, 0, 3, 0, 0, 0);
    tick();
`ifdef HAZARD_PERF_EN
    n_cmp++;
    assert (stall_cnt === 32'd7) else begin
      n_err++;
      $error("FAIL stall_cnt_7: got %0d expected 7", stall_cnt);
    end
`endif
    d_mudv = 1'b0;
    mudv_busy = 1'b0;

    // Random traffic over a small register set to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      set_d(($urandom_range(0, 7) != 0), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3));
      d_mudv    = ($urandom_range(0, 3) == 0);
      mudv_busy = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
